// File: rtl/coin_accum.sv
// Coin/item accumulator with a confirm/cancel settle handshake and saturating totals.
// Optional idle auto-cancel is built when COIN_TIMEOUT_EN is defined.
module coin_accum #(
  parameter int DW          = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          coin_valid,
  input  logic [DW-1:0] coin_value,
  output logic          coin_ready,
  input  logic          item_valid,
  input  logic [DW-1:0] item_price,
  input  logic          confirm,
  input  logic          cancel,
  output logic [DW-1:0] total_insert,
  output logic [DW-1:0] total_price,
  output logic [DW-1:0] input_count,
  output logic          settle_valid,
  input  logic          settle_ready,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, COLLECT, SETTLE} state_t;

  // Ceiling keeps the MSB clear so downstream can treat totals as signed.
  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};

  state_t        state, state_nxt;
  logic          coin_acc, item_acc, in_collect;
  logic          timeout_hit, do_cancel, do_confirm;
  logic [DW:0]   ins_sum, prc_sum, cnt_sum;
  logic [DW-1:0] insert_nxt, price_nxt, count_nxt;
  logic          ovf_nxt;

  // Returns {saturated, value}.
  function automatic logic [DW:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, SAT_MAX}) return {1'b1, SAT_MAX};
    return {1'b0, sum[DW-1:0]};
  endfunction

  assign coin_ready   = (state != SETTLE);
  assign settle_valid = (state == SETTLE);
  assign in_collect   = (state == COLLECT);
  assign coin_acc     = coin_ready & coin_valid;
  assign item_acc     = coin_ready & item_valid;
  assign do_cancel    = in_collect & (cancel | timeout_hit);
  assign do_confirm   = in_collect & confirm & ~do_cancel;

  assign ins_sum = coin_acc ? sat_add(total_insert, coin_value) : {1'b0, total_insert};
  assign prc_sum = item_acc ? sat_add(total_price, item_price)  : {1'b0, total_price};
  assign cnt_sum = item_acc ? sat_add(input_count, DW'(1))      : {1'b0, input_count};

`ifdef COIN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          activity;

  assign activity    = coin_acc | item_acc | confirm | cancel;
  // Fires on the idle cycle that brings the count up to TIMEOUT_CYC.
  assign timeout_hit = in_collect & ~activity & (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      idle_cnt <= '0;
    else if (!in_collect || activity) idle_cnt <= '0;
    else                             idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // No counter: a transaction stays open until confirm or cancel.
  assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_nxt  = state;
    insert_nxt = total_insert;
    price_nxt  = total_price;
    count_nxt  = input_count;
    ovf_nxt    = overflow;
    case (state)
      IDLE:    if (coin_acc || item_acc)      state_nxt = COLLECT;
      COLLECT: if (do_cancel || do_confirm)   state_nxt = SETTLE;
      SETTLE:  if (settle_ready)              state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
    if (coin_ready) begin
      // Same-cycle coins/items land before a confirm or cancel freezes the totals.
      insert_nxt = ins_sum[DW-1:0];
      price_nxt  = do_cancel ? '0 : prc_sum[DW-1:0];
      count_nxt  = do_cancel ? '0 : cnt_sum[DW-1:0];
      ovf_nxt    = overflow | ins_sum[DW] | prc_sum[DW] | cnt_sum[DW];
    end else if (settle_ready) begin
      insert_nxt = '0;
      price_nxt  = '0;
      count_nxt  = '0;
      ovf_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      total_insert <= '0;
      total_price  <= '0;
      input_count  <= '0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      total_insert <= insert_nxt;
      total_price  <= price_nxt;
      input_count  <= count_nxt;
      overflow     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_coin_accum.sv
// Randomized bench for coin_accum against a transaction-level reference model.
// Compile with COIN_TIMEOUT_EN defined to exercise the auto-cancel path.
module tb_coin_accum;

  localparam int DW  = 8;
  localparam int TO  = 4;
  localparam int MAX = (1 << (DW - 1)) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coin_valid, item_valid, confirm, cancel, settle_ready;
  logic [DW-1:0] coin_value, item_price;
  logic          coin_ready, settle_valid, overflow;
  logic [DW-1:0] total_insert, total_price, input_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: phase 0 = idle, 1 = collecting, 2 = settling.
  int m_phase, m_ins, m_prc, m_cnt, m_ovf, m_idle;

  coin_accum #(.DW(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
    .item_valid(item_valid), .item_price(item_price),
    .confirm(confirm), .cancel(cancel),
    .total_insert(total_insert), .total_price(total_price), .input_count(input_count),
    .settle_valid(settle_valid), .settle_ready(settle_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ins = 0; m_prc = 0; m_cnt = 0; m_ovf = 0; m_idle = 0;
  endtask

  function automatic int sat(input int v, inout int ovf);
    if (v > MAX) begin
      ovf = 1;
      return MAX;
    end
    return v;
  endfunction

  task automatic model_step(input bit cv, input int cval, input bit iv, input int ip,
                            input bit cf, input bit cn, input bit sr);
    bit act, hit;
    int ph;
    ph = m_phase;
    if (ph == 2) begin
      m_idle = 0;
      if (sr) begin
        m_ins = 0; m_prc = 0; m_cnt = 0; m_ovf = 0; m_phase = 0;
      end
    end else begin
      act = cv | iv | cf | cn;
      hit = 1'b0;
`ifdef COIN_TIMEOUT_EN
      hit    = (ph == 1) && !act && (m_idle + 1 == TO);
      m_idle = (ph == 1 && !act) ? m_idle + 1 : 0;
`endif
      if (cv) m_ins = sat(m_ins + cval, m_ovf);
      if (iv) begin
        m_prc = sat(m_prc + ip, m_ovf);
        m_cnt = sat(m_cnt + 1, m_ovf);
      end
      if (ph == 0) begin
        if (cv || iv) m_phase = 1;
      end else if (cn || hit) begin
        m_prc = 0; m_cnt = 0; m_phase = 2;
      end else if (cf) begin
        m_phase = 2;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ready"},  int'(coin_ready),   (m_phase != 2) ? 1 : 0);
    check({tag, ".svalid"}, int'(settle_valid), (m_phase == 2) ? 1 : 0);
    check({tag, ".insert"}, int'(total_insert), m_ins);
    check({tag, ".price"},  int'(total_price),  m_prc);
    check({tag, ".count"},  int'(input_count),  m_cnt);
    check({tag, ".ovf"},    int'(overflow),     m_ovf);
  endtask

  // Called at a negedge: drive one cycle, advance the model, sample at the next negedge.
  task automatic apply(input string tag, input bit cv, input int cval, input bit iv,
                       input int ip, input bit cf, input bit cn, input bit sr);
    coin_valid = cv; coin_value = DW'(cval);
    item_valid = iv; item_price = DW'(ip);
    confirm = cf; cancel = cn; settle_ready = sr;
    model_step(cv, cval, iv, ip, cf, cn, sr);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic idle_cyc(input string tag);
    apply(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    bit cv, iv, cf, cn, sr;
    int cval, ip;

    rst_n = 1'b0;
    coin_valid = 0; coin_value = '0; item_valid = 0; item_price = '0;
    confirm = 0; cancel = 0; settle_ready = 0;
    model_reset();
    #3;
    check("rst.ready", int'(coin_ready), 1);
    check_all("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal purchase
    apply("buy.c5", 1, 5, 0, 0, 0, 0, 0);
    check("buy.c5.ins", int'(total_insert), 5);
    apply("buy.c10", 1, 10, 0, 0, 0, 0, 0);
    apply("buy.c20", 1, 20, 0, 0, 0, 0, 0);
    apply("buy.item", 0, 0, 1, 25, 0, 0, 0);
    apply("buy.conf", 0, 0, 0, 0, 1, 0, 0);
    check("buy.svalid", int'(settle_valid), 1);
    check("buy.ins", int'(total_insert), 35);
    check("buy.prc", int'(total_price), 25);
    check("buy.cnt", int'(input_count), 1);
    check("buy.ovf", int'(overflow), 0);
    apply("buy.hs", 0, 0, 0, 0, 0, 0, 1);
    check("buy.hs.ins", int'(total_insert), 0);

    // Cancel refunds
    apply("ref.c50", 1, 50, 0, 0, 0, 0, 0);
    apply("ref.item", 0, 0, 1, 30, 0, 0, 0);
    apply("ref.canc", 0, 0, 0, 0, 0, 1, 0);
    check("ref.ins", int'(total_insert), 50);
    check("ref.prc", int'(total_price), 0);
    check("ref.cnt", int'(input_count), 0);
    apply("ref.hs", 0, 0, 0, 0, 0, 0, 1);

    // Saturation, then a held settle with ignored coins
    apply("sat.c1", 1, 100, 0, 0, 0, 0, 0);
    check("sat.c1.ovf", int'(overflow), 0);
    apply("sat.c2", 1, 100, 0, 0, 0, 0, 0);
    check("sat.c2.ins", int'(total_insert), 127);
    check("sat.c2.ovf", int'(overflow), 1);
    apply("sat.conf", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply("hold", 1, 10, 0, 0, 0, 0, 0);
      check("hold.ins", int'(total_insert), 127);
      check("hold.ready", int'(coin_ready), 0);
    end
    apply("hold.hs", 0, 0, 0, 0, 0, 0, 1);
    check("hold.hs.svalid", int'(settle_valid), 0);
    check("hold.hs.ovf", int'(overflow), 0);

    // Coin with confirm and cancel together
    apply("both.item", 0, 0, 1, 7, 0, 0, 0);
    apply("both.go", 1, 20, 0, 0, 1, 1, 0);
    check("both.ins", int'(total_insert), 20);
    check("both.prc", int'(total_price), 0);
    check("both.cnt", int'(input_count), 0);
    apply("both.hs", 0, 0, 0, 0, 0, 0, 1);

    // confirm/cancel alone in idle are ignored
    apply("idle.conf", 0, 0, 0, 0, 1, 0, 0);
    check("idle.conf.svalid", int'(settle_valid), 0);
    apply("idle.canc", 0, 0, 0, 0, 0, 1, 0);
    check("idle.canc.svalid", int'(settle_valid), 0);

    apply("to.c10", 1, 10, 0, 0, 0, 0, 0);
`ifdef COIN_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      idle_cyc("to.wait");
      check("to.wait.svalid", int'(settle_valid), 0);
    end
    idle_cyc("to.fire");
    check("to.svalid", int'(settle_valid), 1);
    check("to.ins", int'(total_insert), 10);
    check("to.prc", int'(total_price), 0);
`else
    for (int i = 0; i < 20; i++) idle_cyc("noto.wait");
    check("noto.svalid", int'(settle_valid), 0);
    apply("noto.conf", 0, 0, 0, 0, 1, 0, 0);
    check("noto.conf.svalid", int'(settle_valid), 1);
`endif
    apply("to.hs", 0, 0, 0, 0, 0, 0, 1);

    // Asynchronous reset in the middle of a transaction
    apply("ar.c30", 1, 30, 0, 0, 0, 0, 0);
    apply("ar.item", 0, 0, 1, 9, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("ar.ins", int'(total_insert), 0);
    check("ar.ready", int'(coin_ready), 1);
    check_all("ar");
    @(negedge clk);
    rst_n = 1'b1;
    idle_cyc("ar.after");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all("rnd.rst");
        @(negedge clk);
        rst_n = 1'b1;
      end
      cv   = ($urandom_range(0, 99) < 40);
      cval = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      iv   = ($urandom_range(0, 99) < 25);
      ip   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
      cf   = ($urandom_range(0, 99) < 8);
      cn   = ($urandom_range(0, 99) < 4);
      sr   = ($urandom_range(0, 99) < 40);
      apply("rnd", cv, cval, iv, ip, cf, cn, sr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
